csc_rgb_packer: RTL

CSC_RGB_PACKER -- requirements
Module: csc_rgb_packer

---
 rtl/csc_rgb_packer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/csc_rgb_packer.sv
// YUV to RGB888 colour-space converter that packs pixel pairs into three 16-bit SRAM words.
// Three-stage conversion pipeline feeding an even/odd/flush packer with a per-frame word count.
module csc_rgb_packer #(
   parameter int unsigned PIXEL_COUNT = 76800
) (
   input  logic        Clock_50,
   input  logic        Reset,
   input  logic        start,
   input  logic [17:0] base_address,
   input  logic        in_valid,
   input  logic [7:0]  Y_in,
   input  logic [7:0]  U_in,
   input  logic [7:0]  V_in,
   output logic        in_ready,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic        busy,
   output logic        done
);

   localparam logic [16:0] PixTotal  = 17'(PIXEL_COUNT);
   localparam logic [17:0] WordTotal = 18'(3 * PIXEL_COUNT / 2);

   typedef enum logic [1:0] {S_EVEN, S_ODD, S_FLUSH} state_e;

   state_e             state_q, state_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic [16:0]        pix_q, pix_d;
   logic [17:0]        wcnt_q, wcnt_d;
   logic [17:0]        naddr_q, naddr_d, addr_q, addr_d;
   logic [15:0]        wdata_q, wdata_d;
   logic               we_n_q, we_n_d;

   logic               v1_q, v2_q, v3_q;
   logic signed [31:0] yp_q, up_q, vp_q;
   logic signed [31:0] py_q, prv_q, pgu_q, pgv_q, pbu_q;
   logic [7:0]         r3_q, g3_q, b3_q;
   logic [7:0]         r_c, g_c, b_c;
   logic               advance, accept;

   function automatic logic [7:0] clip8(input logic signed [31:0] v);
      if (v < 0) return 8'd0;
      else if (v > 255) return 8'hFF;
      else return v[7:0];
   endfunction

   // The whole pipeline freezes while the third word of a pair is written.
   assign advance  = (state_q != S_FLUSH);
   assign in_ready = busy_q && (pix_q < PixTotal) && advance;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge Clock_50 or posedge Reset) begin
      if (Reset) begin
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         v3_q  <= 1'b0;
         yp_q  <= '0;
         up_q  <= '0;
         vp_q  <= '0;
         py_q  <= '0;
         prv_q <= '0;
         pgu_q <= '0;
         pgv_q <= '0;
         pbu_q <= '0;
         r3_q  <= '0;
         g3_q  <= '0;
         b3_q  <= '0;
      end else if (advance) begin
         v1_q <= accept;
         v2_q <= v1_q;
         v3_q <= v2_q;
         if (accept) begin
            yp_q <= $signed({24'd0, Y_in}) - 32'sd16;
            up_q <= $signed({24'd0, U_in}) - 32'sd128;
            vp_q <= $signed({24'd0, V_in}) - 32'sd128;
         end
         if (v1_q) begin
            py_q  <= 32'sd76284 * yp_q;
            prv_q <= 32'sd104595 * vp_q;
            pgu_q <= 32'sd25624 * up_q;
            pgv_q <= 32'sd53281 * vp_q;
            pbu_q <= 32'sd132251 * up_q;
         end
         if (v2_q) begin
            r3_q <= r_c;
            g3_q <= g_c;
            b3_q <= b_c;
         end
      end
   end

   // Sum/shift/clip stage; its result is written the same edge it is captured.
   always_comb begin
      r_c = clip8((py_q + prv_q) >>> 16);
      g_c = clip8((py_q - pgu_q - pgv_q) >>> 16);
      b_c = clip8((py_q + pbu_q) >>> 16);
   end

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pix_d   = pix_q + {16'd0, accept};
      wcnt_d  = wcnt_q;
      naddr_d = naddr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_n_d  = 1'b1;
      if (!busy_q) begin
         if (start) begin
            busy_d  = 1'b1;
            pix_d   = '0;
            wcnt_d  = '0;
            naddr_d = base_address;
            state_d = S_EVEN;
         end
      end else begin
         if (!we_n_q && (wcnt_q == WordTotal)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
         unique case (state_q)
            S_EVEN: if (v2_q) begin
               we_n_d  = 1'b0;
               wdata_d = {r_c, g_c};
               state_d = S_ODD;
            end
            S_ODD: if (v2_q) begin
               we_n_d  = 1'b0;
               wdata_d = {b3_q, r_c};
               state_d = S_FLUSH;
            end
            S_FLUSH: if (v3_q) begin
               we_n_d  = 1'b0;
               wdata_d = {g3_q, b3_q};
               state_d = S_EVEN;
            end
            default: state_d = S_EVEN;
         endcase
         if (!we_n_d) begin
            addr_d  = naddr_q;
            naddr_d = naddr_q + 18'd1;
            wcnt_d  = wcnt_q + 18'd1;
         end
      end
   end

   always_ff @(posedge Clock_50 or posedge Reset) begin
      if (Reset) begin
         state_q <= S_EVEN;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pix_q   <= '0;
         wcnt_q  <= '0;
         naddr_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pix_q   <= pix_d;
         wcnt_q  <= wcnt_d;
         naddr_q <= naddr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_n_q  <= we_n_d;
      end
   end

   assign SRAM_address    = addr_q;
   assign SRAM_write_data = wdata_q;
   assign SRAM_we_n       = we_n_q;
   assign busy            = busy_q;
   assign done            = done_q;

endmodule
